// File: rtl/output_layer.sv
// Output neuron of the drowsiness detector: serial MAC over the hidden activations,
// saturating ReLU, registered score, Drowsy flag and a one-cycle Done pulse.
module output_layer #(
    parameter int N_IN   = 5,
    parameter int DW     = 10,
    parameter int WW     = 10,
    parameter int FRAC   = 4,
    parameter int THRESH = 512
) (
    input  logic                 Clock,
    input  logic                 Rst,
    input  logic                 In,
    input  logic                 WE,
    input  logic [2:0]           WAddr,
    input  logic [WW-1:0]        WData,
    input  logic [DW*N_IN-1:0]   hidVal,
    output logic [DW-1:0]        outVal,
    output logic                 Drowsy,
    output logic                 Done,
    output logic                 Busy
);

    localparam int ACC_W = DW + WW + 1 + $clog2(N_IN + 1);
    localparam int PW    = DW + WW + 1;
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [2:0]              BIAS_ADDR = 3'(N_IN);
    localparam logic [IW-1:0]           LAST_IDX  = IW'(N_IN - 1);
    localparam logic [DW-1:0]           THR       = DW'(THRESH);
    localparam logic signed [ACC_W-1:0] MAX_OUT   = ACC_W'((1 << DW) - 1);

    typedef enum logic [1:0] {IDLE, MAC, ACT} state_t;

    // Floor-rescale the accumulator to integer and clamp into the unsigned output range.
    function automatic logic [DW-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = a >>> FRAC;
        if (r[ACC_W-1])
            return '0;
        if (r > MAX_OUT)
            return '1;
        return r[DW-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DW-1:0]           out_q, out_d;
    logic                    drowsy_q, drowsy_d;
    logic                    done_q, done_d;
    logic [DW-1:0]           h_q [N_IN];
    logic signed [WW-1:0]    w_q [N_IN];
    logic signed [WW-1:0]    bias_q;
    // A weight overwritten on the start edge keeps its old value here for that run.
    logic                    old_vld_q;
    logic [2:0]              old_addr_q;
    logic signed [WW-1:0]    old_w_q;

    logic signed [WW-1:0]    wsel;
    logic signed [PW-1:0]    prod;
    logic                    start, wr_ok;

    assign start = (state_q == IDLE) && In;
    assign wr_ok = (state_q == IDLE) && WE;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        out_d    = out_q;
        drowsy_d = drowsy_q;
        done_d   = 1'b0;
        wsel     = (old_vld_q && (old_addr_q == 3'(idx_q))) ? old_w_q : w_q[idx_q];
        prod     = $signed({1'b0, h_q[idx_q]}) * wsel;
        case (state_q)
            IDLE: begin
                if (In) begin
                    state_d = MAC;
                    idx_d   = '0;
                    acc_d   = {{(ACC_W-WW){bias_q[WW-1]}}, bias_q};
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX)
                    state_d = ACT;
            end
            ACT: begin
                out_d    = relu_sat(acc_q);
                drowsy_d = (out_d >= THR);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            drowsy_q   <= 1'b0;
            done_q     <= 1'b0;
            bias_q     <= '0;
            old_vld_q  <= 1'b0;
            old_addr_q <= '0;
            old_w_q    <= '0;
            for (int i = 0; i < N_IN; i++) begin
                h_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            drowsy_q <= drowsy_d;
            done_q   <= done_d;
            if (start) begin
                for (int i = 0; i < N_IN; i++)
                    h_q[i] <= hidVal[i*DW +: DW];
                old_vld_q  <= WE && (WAddr < BIAS_ADDR);
                old_addr_q <= WAddr;
                if (WAddr < BIAS_ADDR)
                    old_w_q <= w_q[WAddr];
            end
            if (wr_ok) begin
                if (WAddr < BIAS_ADDR)
                    w_q[WAddr] <= WData;
                else if (WAddr == BIAS_ADDR)
                    bias_q <= WData;
            end
        end
    end

    assign outVal = out_q;
    assign Drowsy = drowsy_q;
    assign Done   = done_q;
    assign Busy   = (state_q != IDLE);

endmodule
